read_adc_serial: RTL and testbench

READ_ADC_SERIAL -- requirements
Module: read_adc_serial

---
 rtl/read_adc_serial.sv | 129 ++++++++++++
 tb/tb_read_adc_serial.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/read_adc_serial.sv
// Serial ADC frame reader: waits for a DRDYnot falling edge, clocks in one
// MSB-first word on SCLK, and presents it with a valid/ready handshake.
module read_adc_serial #(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 DRDYnot,
  input  logic                 DOUT,
  output logic                 SCLK,
  output logic                 RFSnot,
  output logic [WORD_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF  = CLK_DIV / 2;
  localparam int DIV_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int CNT_W = $clog2(WORD_BITS + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state;
  logic [DIV_W-1:0]     div;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WORD_BITS-1:0] shreg;
  logic                 drdy_meta;
  logic                 drdy_sync;
  logic                 drdy_prev;
  logic                 drdy_fall;
  logic                 half_done;

  assign drdy_fall = drdy_prev & ~drdy_sync;
  assign half_done = (div == DIV_W'(HALF - 1));
  assign busy      = (state != IDLE);

  // NOTE: synchronizer flops reset to 1 (the idle level of DRDYnot), so a
  // line that stays high across reset never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      drdy_meta <= 1'b1;
      drdy_sync <= 1'b1;
      drdy_prev <= 1'b1;
    end else begin
      drdy_meta <= DRDYnot;
      drdy_sync <= drdy_meta;
      drdy_prev <= drdy_sync;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments; the later
  // data_valid <= 1 in DONE deliberately overrides the consume clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      div        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      SCLK       <= 1'b1;
      RFSnot     <= 1'b1;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (data_valid && data_ready) data_valid <= 1'b0;

      case (state)
        IDLE: begin
          SCLK   <= 1'b1;
          RFSnot <= 1'b1;
          if (drdy_fall && enable) begin
            state   <= SETUP;
            RFSnot  <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
          end
        end

        SETUP: begin
          if (half_done) begin
            state <= SHIFT;
            SCLK  <= 1'b0;
            div   <= '0;
          end else begin
            div <= div + 1'b1;
          end
        end

        SHIFT: begin
          if (half_done) begin
            div <= '0;
            if (!SCLK) begin
              // Rising SCLK: capture the bit the ADC set up on the falling edge.
              SCLK    <= 1'b1;
              shreg   <= {shreg[WORD_BITS-2:0], DOUT};
              bit_cnt <= bit_cnt + 1'b1;
            end else if (bit_cnt == CNT_W'(WORD_BITS)) begin
              state  <= DONE;
              RFSnot <= 1'b1;
            end else begin
              SCLK <= 1'b0;
            end
          end else begin
            div <= div + 1'b1;
          end
        end

        DONE: begin
          state      <= IDLE;
          SCLK       <= 1'b1;
          RFSnot     <= 1'b1;
          data_out   <= shreg;
          data_valid <= 1'b1;
          if (data_valid && !data_ready) overrun <= 1'b1;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_read_adc_serial.sv
// Directed-sequence bench for read_adc_serial with random words, an ADC
// behavioural model, and a word-level reference model of the handshake.
module tb_read_adc_serial;

  localparam int CLK_DIV = 4;
  localparam int W       = 24;
  localparam int HALF    = CLK_DIV / 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b1;
  logic         DRDYnot = 1'b1;
  logic         DOUT = 1'b0;
  logic         SCLK;
  logic         RFSnot;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic         overrun;
  logic         busy;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // reference model state
  logic [W-1:0] exp_data    = '0;
  logic         exp_valid   = 1'b0;
  logic         exp_overrun = 1'b0;

  // ADC model state
  logic [W-1:0] adc_word = '0;
  int           adc_idx  = -1;

  read_adc_serial #(.CLK_DIV(CLK_DIV), .WORD_BITS(W)) dut (
    .clk(clk), .rst(rst), .enable(enable), .DRDYnot(DRDYnot), .DOUT(DOUT),
    .SCLK(SCLK), .RFSnot(RFSnot), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .overrun(overrun), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // ADC presents the next bit, MSB first, on every SCLK falling edge.
  initial forever begin
    @(negedge SCLK);
    if (adc_idx >= 0) begin
      DOUT = adc_word[adc_idx];
      adc_idx--;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_data"},    data_out,   exp_data);
    check({tag, "_valid"},   data_valid, exp_valid);
    check({tag, "_overrun"}, overrun,    exp_overrun);
  endtask

  task automatic apply_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_data = '0; exp_valid = 1'b0; exp_overrun = 1'b0;
  endtask

  task automatic consume();
    @(negedge clk); data_ready = 1'b1;
    @(posedge clk); #1; data_ready = 1'b0;
    exp_valid = 1'b0;
    check("consume_valid", data_valid, 0);
  endtask

  task automatic pulse_drdy();
    @(negedge clk); DRDYnot = 1'b0;
    repeat (6) @(negedge clk);
    DRDYnot = 1'b1;
  endtask

  task automatic run_frame(input logic [W-1:0] word, input bit ready_done,
                           input bit glitch, input bit drop_enable);
    int   lat;
    int   t;
    int   rises;
    int   first_fall;
    logic prev_sclk;
    adc_word = word;
    adc_idx  = W - 1;
    @(negedge clk); DRDYnot = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (RFSnot && lat < 10);
    check("latency", lat, 3);

    t = 0; rises = 0; first_fall = -1; prev_sclk = SCLK;
    while (!RFSnot && t < 500) begin
      @(posedge clk); #1; t++;
      if (t == 5) DRDYnot = 1'b1;
      if (glitch && t == 30) DRDYnot = 1'b0;
      if (glitch && t == 40) DRDYnot = 1'b1;
      if (drop_enable && t == 20) enable = 1'b0;
      if (t == 50) check("busy_mid", busy, 1);
      if (SCLK && !prev_sclk) rises++;
      if (!SCLK && first_fall < 0) first_fall = t;
      prev_sclk = SCLK;
    end
    check("frame_len", t, HALF * (1 + 2 * W));
    check("sclk_rises", rises, W);
    check("first_fall", first_fall, HALF);

    // Now inside the DONE cycle: optionally consume alongside the load.
    data_ready = ready_done;
    @(posedge clk); #1;
    data_ready = 1'b0;
    if (exp_valid && !ready_done) exp_overrun = 1'b1;
    exp_data  = word;
    exp_valid = 1'b1;
    check_model("frame");
    check("busy_after", busy, 0);
  endtask

  initial begin
    logic [W-1:0] w;
    int   rises;
    int   guard;
    int   seen_valid;
    logic prev_sclk;

    apply_reset();
    #1;
    check("rst_sclk", SCLK, 1);
    check("rst_rfs", RFSnot, 1);
    check("rst_busy", busy, 0);
    check_model("rst");

    // Reference word, then consume it.
    run_frame(24'hA5C3F0, 1'b0, 1'b0, 1'b0);
    consume();

    // Two unconsumed frames: second overwrites and raises overrun.
    run_frame(24'h000001, 1'b0, 1'b0, 1'b0);
    run_frame(24'hFFFFFE, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 check_model("overrun_hold");

    // Consume coinciding with the next load: no overrun.
    apply_reset();
    w = W'($urandom);
    run_frame(w, 1'b0, 1'b0, 1'b0);
    w = W'($urandom);
    run_frame(w, 1'b1, 1'b0, 1'b0);
    consume();

    // DRDYnot toggled mid-frame must not start an extra frame.
    w = W'($urandom);
    run_frame(w, 1'b0, 1'b1, 1'b0);
    repeat (20) @(posedge clk);
    #1 check("glitch_busy", busy, 0);
    check_model("glitch_hold");
    consume();

    // enable dropped mid-frame: frame completes, then no new frame.
    w = W'($urandom);
    run_frame(w, 1'b0, 1'b0, 1'b1);
    pulse_drdy();
    repeat (10) @(posedge clk);
    #1 check("disabled_busy", busy, 0);
    check("disabled_rfs", RFSnot, 1);
    check_model("disabled_hold");
    enable = 1'b1;

    // Reset after 10 SCLK rising edges aborts the frame.
    adc_word = W'($urandom);
    adc_idx  = W - 1;
    @(negedge clk); DRDYnot = 1'b0;
    rises = 0; guard = 0; prev_sclk = SCLK;
    while (rises < 10 && guard < 500) begin
      @(posedge clk); #1; guard++;
      if (guard == 5) DRDYnot = 1'b1;
      if (SCLK && !prev_sclk) rises++;
      prev_sclk = SCLK;
    end
    check("abort_rises", rises, 10);
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    exp_data = '0; exp_valid = 1'b0; exp_overrun = 1'b0;
    check("abort_sclk", SCLK, 1);
    check("abort_rfs", RFSnot, 1);
    check("abort_busy", busy, 0);
    check_model("abort");
    seen_valid = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (data_valid) seen_valid++;
    end
    check("abort_no_word", seen_valid, 0);
    check("abort_idle", busy, 0);

    // Fresh frame after reset works normally.
    w = W'($urandom);
    run_frame(w, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
